// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle arithmetic/logic/compare, iterative 1-bit/cycle shifts.
// Define ALU_MC_MUL_EN to add the WIDTH-cycle shift-add MUL/MULHU datapath.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   sh_step;
  logic               last_step;
  logic               accept;
  logic [SHAMT_W-1:0] amt;

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] acc_step;

  // Right-shifting multiplier: low half starts as the multiplier, partial sums enter the top.
  always_comb begin
    acc_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {acc_sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    case (op_q)
      OP_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  assign amt       = alu_in2[SHAMT_W-1:0];
  assign last_step = (cnt_q == CNT_W'(1));
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy_o    = (state_q == S_BUSY);
  assign result_o  = result_q;
  assign err_o     = err_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef ALU_MC_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
`endif

    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_MC_MUL_EN
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
          acc_d = acc_step;
          if (last_step) begin
            result_d = (op_q == OP_MUL) ? acc_step[WIDTH-1:0] : acc_step[2*WIDTH-1:WIDTH];
            state_d  = S_DONE;
          end
        end else
`endif
        begin
          sh_d = sh_step;
          if (last_step) begin
            result_d = sh_step;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the DONE->IDLE exit so back-to-back ops flow every cycle.
    if (accept) begin
      op_d    = alu_ctrl;
      err_d   = 1'b0;
      state_d = S_DONE;
      case (alu_ctrl)
        OP_ADD:  result_d = alu_in1 + alu_in2;
        OP_SUB:  result_d = alu_in1 - alu_in2;
        OP_XOR:  result_d = alu_in1 ^ alu_in2;
        OP_OR:   result_d = alu_in1 | alu_in2;
        OP_AND:  result_d = alu_in1 & alu_in2;
        OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (alu_in1 < alu_in2)};
        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(alu_in1) < $signed(alu_in2))};
        OP_SLL, OP_SRL, OP_SRA: begin
          if (amt == '0) begin
            result_d = alu_in1;
          end else begin
            sh_d    = alu_in1;
            cnt_d   = {1'b0, amt};
            state_d = S_BUSY;
          end
        end
`ifdef ALU_MC_MUL_EN
        OP_MUL, OP_MULHU: begin
          acc_d   = {{WIDTH{1'b0}}, alu_in2};
          mcand_d = alu_in1;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_BUSY;
        end
`endif
        default: begin
          result_d = '0;
          err_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef ALU_MC_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_o;
  logic        err_o;
  logic        busy_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_o  (result_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: result, error flag and accept-to-out_valid latency in cycles.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    int amt;
    logic [63:0] p;
    amt = int'(b[4:0]);
    r = 32'd0; e = 1'b0; lat = 1; p = 64'd0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a ^ b;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: begin r = a << amt; lat = amt + 1; end
      4'd6: begin r = a >> amt; lat = amt + 1; end
      4'd7: begin r = $signed(a) >>> amt; lat = amt + 1; end
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      4'd9: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MC_MUL_EN
      4'd10, 4'd11: begin
        p = {32'd0, a} * {32'd0, b};
        r = (op == 4'd10) ? p[31:0] : p[63:32];
        lat = 33;
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Issues one op from IDLE with out_ready=1 and reports what came back; callers compare.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic err, output int lat, output int bsy);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = op;
    alu_in1   = a;
    alu_in2   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    alu_in1  = $urandom;
    alu_in2  = $urandom;
    lat = 1;
    bsy = 0;
    while (!out_valid && lat < 200) begin
      if (busy_o) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    err = err_o;
    $display("txn op=%0d a=%h b=%h -> res=%h err=%0d lat=%0d busy=%0d", op, a, b, res, err, lat, bsy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 4'd0; alu_in1 = 32'd0; alu_in2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, result_o, err_o, busy_o, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: got valid=%0d res=%h err=%0d busy=%0d rdy=%0d, want 0 0 0 0 1",
               out_valid, result_o, err_o, busy_o, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [31:0] r; logic e; int l, b;
    run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'h0000_0001, 1'b0, 1})
      $display("FAIL add_wrap: got res=%h err=%0d lat=%0d, want res=00000001 err=0 lat=1", r, e, l);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  sc_ops [11];
    logic [3:0]  op;
    logic [31:0] a, b, er;
    logic        ee;
    int          l;
    sc_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        op = 4'd3; a = 32'hF0F0_0000; b = 32'h0000_000F; er = 32'hF0F0_000F; ee = 1'b0;
      end else if (i == 1) begin
        op = 4'd4; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F; er = 32'h0F00_0F00; ee = 1'b0;
      end else begin
        op = sc_ops[$urandom_range(0, 10)]; a = $urandom; b = $urandom;
        model(op, a, b, er, ee, l);
      end
      in_valid = 1'b1; alu_ctrl = op; alu_in1 = a; alu_in2 = b;
      total_cnt++;
      if (in_ready !== 1'b1)
        $display("FAIL b2b_ready[%0d]: got in_ready=%0d, want 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      $display("txn b2b op=%0d a=%h b=%h -> valid=%0d res=%h err=%0d", op, a, b, out_valid, result_o, err_o);
      total_cnt++;
      if ({out_valid, err_o, result_o} !== {1'b1, ee, er})
        $display("FAIL b2b_result[%0d]: got valid=%0d err=%0d res=%h, want valid=1 err=%0d res=%h",
                 i, out_valid, err_o, result_o, ee, er);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_shifts;
    logic [31:0] r; logic e; int l, b;
    run_op(4'd7, 32'h8000_0000, 32'd4, r, e, l, b);
    total_cnt++;
    if ({r, e, l, b} !== {32'hF800_0000, 1'b0, 5, 4})
      $display("FAIL sra4: got res=%h err=%0d lat=%0d busy=%0d, want F8000000 0 5 4", r, e, l, b);
    else pass_cnt++;
    run_op(4'd6, 32'h8000_0000, 32'd4, r, e, l, b);
    total_cnt++;
    if ({r, e, l, b} !== {32'h0800_0000, 1'b0, 5, 4})
      $display("FAIL srl4: got res=%h err=%0d lat=%0d busy=%0d, want 08000000 0 5 4", r, e, l, b);
    else pass_cnt++;
    run_op(4'd5, 32'h0000_0001, 32'hFFFF_FFE0, r, e, l, b);
    total_cnt++;
    if ({r, e, l, b} !== {32'h0000_0001, 1'b0, 1, 0})
      $display("FAIL sll0: got res=%h err=%0d lat=%0d busy=%0d, want 00000001 0 1 0", r, e, l, b);
    else pass_cnt++;
    run_op(4'd5, 32'h0000_0003, 32'd31, r, e, l, b);
    total_cnt++;
    if ({r, e, l, b} !== {32'h8000_0000, 1'b0, 32, 31})
      $display("FAIL sll31: got res=%h err=%0d lat=%0d busy=%0d, want 80000000 0 32 31", r, e, l, b);
    else pass_cnt++;
  endtask

  task automatic test_compare_illegal;
    logic [31:0] r; logic e; int l, b;
    run_op(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'd1, 1'b0, 1})
      $display("FAIL slt: got res=%h err=%0d lat=%0d, want 00000001 0 1", r, e, l);
    else pass_cnt++;
    run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'd0, 1'b0, 1})
      $display("FAIL sltu: got res=%h err=%0d lat=%0d, want 00000000 0 1", r, e, l);
    else pass_cnt++;
    run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'd0, 1'b1, 1})
      $display("FAIL illegal13: got res=%h err=%0d lat=%0d, want 00000000 1 1", r, e, l);
    else pass_cnt++;
  endtask

  task automatic test_mul;
    logic [31:0] r; logic e; int l, b;
`ifdef ALU_MC_MUL_EN
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, l, b);
    total_cnt++;
    if ({r, e, l, b} !== {32'h0000_0001, 1'b0, 33, 32})
      $display("FAIL mul: got res=%h err=%0d lat=%0d busy=%0d, want 00000001 0 33 32", r, e, l, b);
    else pass_cnt++;
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'hFFFF_FFFE, 1'b0, 33})
      $display("FAIL mulhu: got res=%h err=%0d lat=%0d, want FFFFFFFE 0 33", r, e, l);
    else pass_cnt++;
`else
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'd0, 1'b1, 1})
      $display("FAIL mul_disabled: got res=%h err=%0d lat=%0d, want 00000000 1 1", r, e, l);
    else pass_cnt++;
    run_op(4'd11, 32'h0000_0003, 32'h0000_0005, r, e, l, b);
    total_cnt++;
    if ({r, e, l} !== {32'd0, 1'b1, 1})
      $display("FAIL mulhu_disabled: got res=%h err=%0d lat=%0d, want 00000000 1 1", r, e, l);
    else pass_cnt++;
`endif
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1; alu_ctrl = 4'd0; alu_in1 = 32'd5; alu_in2 = 32'd7;
    @(posedge clk); #1;
    alu_ctrl = 4'd1; alu_in1 = 32'hDEAD_BEEF; alu_in2 = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      $display("txn hold[%0d] -> valid=%0d res=%h err=%0d rdy=%0d", i, out_valid, result_o, err_o, in_ready);
      total_cnt++;
      if ({out_valid, result_o, err_o, in_ready} !== {1'b1, 32'd12, 1'b0, 1'b0})
        $display("FAIL hold[%0d]: got valid=%0d res=%h err=%0d rdy=%0d, want 1 0000000c 0 0",
                 i, out_valid, result_o, err_o, in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1})
      $display("FAIL release: got valid=%0d rdy=%0d, want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_ctrl = 4'd5; alu_in1 = 32'd1; alu_in2 = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (busy_o !== 1'b1) $display("FAIL midrst_busy: got busy=%0d, want 1", busy_o);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy_o, in_ready, result_o, err_o} !== {1'b0, 1'b0, 1'b1, 32'd0, 1'b0})
      $display("FAIL midrst_state: got valid=%0d busy=%0d rdy=%0d res=%h err=%0d, want 0 0 1 0 0",
               out_valid, busy_o, in_ready, result_o, err_o);
    else pass_cnt++;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid || busy_o) seen++;
    end
    $display("txn midrst -> stray activity cycles=%0d", seen);
    total_cnt++;
    if (seen != 0) $display("FAIL midrst_quiet: got %0d active cycles, want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b, r, er;
    logic        e, ee;
    int          l, el, bs;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      model(op, a, b, er, ee, el);
      run_op(op, a, b, r, e, l, bs);
      total_cnt++;
      if ({r, e, l, bs} !== {er, ee, el, el - 1})
        $display("FAIL rand[%0d] op=%0d: got res=%h err=%0d lat=%0d busy=%0d, want res=%h err=%0d lat=%0d busy=%0d",
                 i, op, r, e, l, bs, er, ee, el, el - 1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_shifts;
    test_compare_illegal;
    test_mul;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
